// File: rtl/dtree_frame_sequencer_if.sv
// Handshake bundle between the byte source / result sink and the frame sequencer.
// The sequencer uses the slave modport; the source/sink side uses master.
interface dtree_frame_sequencer_if #(
  parameter int FEAT_W  = 8,
  parameter int CLASS_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [FEAT_W-1:0]  in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_class
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_class
  );
endinterface

// File: rtl/dtree_frame_sequencer.sv
// Assembles a serial feature frame onto the decision-tree input bus, waits for the
// tree to settle, then captures and returns its class over a valid/ready handshake.
module dtree_frame_sequencer #(
  parameter int NUM_FEAT = 5,
  parameter int FEAT_W   = 8,
  parameter int CLASS_W  = 5,
  parameter int SETTLE   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  dtree_frame_sequencer_if.slave     bus,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]         class_in,
  output logic                       err_frame,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FEAT - 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE_ST = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [SET_W-1:0]            settle_q, settle_d;
  logic [NUM_FEAT*FEAT_W-1:0]  feat_q, feat_d;
  logic                        out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]          out_class_q, out_class_d;
  logic                        err_q, err_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        in_ready;

  assign in_ready      = (state_q == LOAD);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign feat_bus      = feat_q;
  assign err_frame     = err_q;
  assign frame_cnt     = cnt_q;

  // Every accepted byte lands in its slot, even in a malformed frame; errors only restart idx.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    feat_d      = feat_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      LOAD: begin
        if (bus.in_valid && in_ready) begin
          feat_d[idx_q*FEAT_W +: FEAT_W] = bus.in_data;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.in_last) begin
              state_d  = SETTLE_ST;
              settle_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.in_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      SETTLE_ST: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_END) begin
          out_class_d = class_in;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + 1'b1;
          state_d     = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      settle_q    <= '0;
      feat_q      <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      feat_q      <= feat_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dtree_frame_sequencer.sv
// Directed bench for dtree_frame_sequencer: nominal frame, back-pressure, malformed
// frames, mid-operation reset and frame counter wrap (counter narrowed to 4 bits).
module tb_dtree_frame_sequencer;

  localparam int NUM_FEAT = 5;
  localparam int FEAT_W   = 8;
  localparam int CLASS_W  = 5;
  localparam int SETTLE   = 2;
  localparam int CNT_W    = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_FEAT*FEAT_W-1:0] feat_bus;
  logic [CLASS_W-1:0]         class_in;
  logic                       err_frame;
  logic [CNT_W-1:0]           frame_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  dtree_frame_sequencer_if #(.FEAT_W(FEAT_W), .CLASS_W(CLASS_W)) bus ();

  dtree_frame_sequencer #(
    .NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
    .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .feat_bus(feat_bus),
    .class_in(class_in),
    .err_frame(err_frame),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] data);
    for (int k = 0; k < NUM_FEAT; k++)
      send_byte(data[k*8 +: 8], (k == NUM_FEAT - 1));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.out_class !== 5'd0) $display("[TB] FAIL reset_out_class: got %0d expected 0", bus.out_class); else pass_cnt++;
    chk_cnt++; if (err_frame !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err_frame); else pass_cnt++;
    chk_cnt++; if (feat_bus !== 40'h0) $display("[TB] FAIL reset_feat_bus: got %h expected 0", feat_bus); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 4'd0) $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_nominal();
    int n;
    class_in      = 5'd17;
    bus.out_ready = 1'b1;
    send_frame(40'h80_40_30_20_10);
    chk_cnt++; if (feat_bus !== 40'h8040302010) $display("[TB] FAIL nom_feat_bus: got %h expected 8040302010", feat_bus); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL nom_in_ready_settle: got %b expected 0", bus.in_ready); else pass_cnt++;
    wait_valid(n);
    chk_cnt++; if (n != 2) $display("[TB] FAIL nom_latency: got %0d expected 2 cycles after last-accept cycle", n); else pass_cnt++;
    chk_cnt++; if (bus.out_class !== 5'd17) $display("[TB] FAIL nom_out_class: got %0d expected 17", bus.out_class); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL nom_out_valid_drop: got %b expected 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 4'd1) $display("[TB] FAIL nom_frame_cnt: got %0d expected 1", frame_cnt); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL nom_in_ready_after: got %b expected 1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    int n;
    class_in      = 5'd17;
    bus.out_ready = 1'b0;
    send_frame(40'h05_04_03_02_01);
    wait_valid(n);
    chk_cnt++; if (n != 2) $display("[TB] FAIL bp_latency: got %0d expected 2", n); else pass_cnt++;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      class_in = (i % 2 == 0) ? 5'd1 : 5'd17;
      tick();
    end
    class_in = 5'd1;
    chk_cnt++; if (bus.out_class !== 5'd17) $display("[TB] FAIL bp_out_class_hold: got %0d expected 17", bus.out_class); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid_hold: got %b expected 1", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b expected 0", bus.in_ready); else pass_cnt++;
    chk_cnt++; if (feat_bus !== 40'h0504030201) $display("[TB] FAIL bp_feat_bus: got %h expected 0504030201", feat_bus); else pass_cnt++;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 4'd2) $display("[TB] FAIL bp_frame_cnt: got %0d expected 2", frame_cnt); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_in_ready_after: got %b expected 1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_early_last();
    int n;
    bus.out_ready = 1'b1;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b1);
    chk_cnt++; if (err_frame !== 1'b1) $display("[TB] FAIL early_err_pulse: got %b expected 1", err_frame); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL early_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (err_frame !== 1'b0) $display("[TB] FAIL early_err_width: got %b expected 0", err_frame); else pass_cnt++;
    tick();
    tick();
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL early_no_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 4'd2) $display("[TB] FAIL early_frame_cnt: got %0d expected 2", frame_cnt); else pass_cnt++;
    class_in = 5'd9;
    send_frame(40'h55_44_33_22_11);
    chk_cnt++; if (feat_bus !== 40'h5544332211) $display("[TB] FAIL early_next_feat: got %h expected 5544332211", feat_bus); else pass_cnt++;
    wait_valid(n);
    chk_cnt++; if (bus.out_class !== 5'd9) $display("[TB] FAIL early_next_class: got %0d expected 9", bus.out_class); else pass_cnt++;
    tick();
    chk_cnt++; if (frame_cnt !== 4'd3) $display("[TB] FAIL early_next_cnt: got %0d expected 3", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_missing_last();
    int n;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NUM_FEAT; k++)
      send_byte(8'hC0 + 8'(k), 1'b0);
    chk_cnt++; if (err_frame !== 1'b1) $display("[TB] FAIL miss_err_pulse: got %b expected 1", err_frame); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL miss_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
    chk_cnt++; if (feat_bus !== 40'hC4C3C2C1C0) $display("[TB] FAIL miss_feat_kept: got %h expected C4C3C2C1C0", feat_bus); else pass_cnt++;
    send_byte(8'hEE, 1'b0);
    chk_cnt++; if (feat_bus !== 40'hC4C3C2C1EE) $display("[TB] FAIL miss_idx_restart: got %h expected C4C3C2C1EE", feat_bus); else pass_cnt++;
    chk_cnt++; if (err_frame !== 1'b0) $display("[TB] FAIL miss_err_width: got %b expected 0", err_frame); else pass_cnt++;
    class_in = 5'd3;
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    send_byte(8'hE3, 1'b0);
    send_byte(8'hE4, 1'b1);
    wait_valid(n);
    chk_cnt++; if (bus.out_class !== 5'd3) $display("[TB] FAIL miss_next_class: got %0d expected 3", bus.out_class); else pass_cnt++;
    chk_cnt++; if (feat_bus !== 40'hE4E3E2E1EE) $display("[TB] FAIL miss_next_feat: got %h expected E4E3E2E1EE", feat_bus); else pass_cnt++;
    tick();
    chk_cnt++; if (frame_cnt !== 4'd4) $display("[TB] FAIL miss_next_cnt: got %0d expected 4", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5B, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++; if (feat_bus !== 40'h0) $display("[TB] FAIL rstload_feat: got %h expected 0", feat_bus); else pass_cnt++;
    chk_cnt++; if (err_frame !== 1'b0) $display("[TB] FAIL rstload_err: got %b expected 0", err_frame); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rstload_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
    chk_cnt++; if (frame_cnt !== 4'd0) $display("[TB] FAIL rstload_cnt: got %0d expected 0", frame_cnt); else pass_cnt++;
    bus.out_ready = 1'b0;
    class_in      = 5'd22;
    send_frame(40'h0F_0E_0D_0C_0B);
    wait_valid(n);
    chk_cnt++; if (bus.out_class !== 5'd22) $display("[TB] FAIL rsthold_pre_class: got %0d expected 22", bus.out_class); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rsthold_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.out_class !== 5'd0) $display("[TB] FAIL rsthold_class: got %0d expected 0", bus.out_class); else pass_cnt++;
    chk_cnt++; if (feat_bus !== 40'h0) $display("[TB] FAIL rsthold_feat: got %h expected 0", feat_bus); else pass_cnt++;
    chk_cnt++; if (err_frame !== 1'b0) $display("[TB] FAIL rsthold_err: got %b expected 0", err_frame); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rsthold_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    int n;
    bus.out_ready = 1'b1;
    class_in      = 5'd7;
    for (int f = 1; f <= 16; f++) begin
      send_frame(40'h01_02_03_04_05);
      wait_valid(n);
      tick();
      if (f == 15) begin
        chk_cnt++; if (frame_cnt !== 4'd15) $display("[TB] FAIL wrap_cnt_15: got %0d expected 15", frame_cnt); else pass_cnt++;
      end
    end
    chk_cnt++; if (frame_cnt !== 4'd0) $display("[TB] FAIL wrap_cnt_0: got %0d expected 0", frame_cnt); else pass_cnt++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    class_in      = 5'd0;
    test_reset();
    test_nominal();
    test_back_pressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
